// File: rtl/perceptron_mac.sv
// -----------------------------------------------------------------------------
// perceptron_mac
// Streaming multiply-accumulate stage that forms one perceptron's weighted sum
// plus bias. One (x, w) pair is accepted per beat. The end of a vector is marked
// by in_last, or forced after MAX_TERMS beats. The result is a Q.16 sum that
// feeds the activation stage.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     beat valid
//   in_ready     registered ready; 1 from the first edge after reset release
//   in_x, in_w   signed Q8.8 activation and weight
//   in_last      final beat of the vector
//   bias         signed Q8.8 bias, sampled on a vector's first accepted beat
//   sum_valid    one-cycle pulse when sum is updated
//   sum          signed Q(ACC_W-16).16 weighted sum, held between updates
//   overflow_err one-cycle pulse with sum_valid for a force-terminated vector
//   busy         vector partially accepted or a product still in the pipeline
// -----------------------------------------------------------------------------
module perceptron_mac #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 48,
  parameter int MAX_TERMS = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_x,
  input  logic [DATA_W-1:0]        in_w,
  input  logic                     in_last,
  input  logic [DATA_W-1:0]        bias,
  output logic                     sum_valid,
  output logic [ACC_W-1:0]         sum,
  output logic                     overflow_err,
  output logic                     busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(MAX_TERMS + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                   state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [CNT_W-1:0]         cnt_next_s;
  logic                     accept_s;
  logic                     first_s;
  logic                     force_s;
  logic                     last_s;
  logic                     stay_accum_s;
  logic signed [PROD_W-1:0] prod_s;

  logic [PROD_W-1:0]        p1_r;
  logic                     p1_valid_r;
  logic                     p1_first_r;
  logic                     p1_last_r;
  logic                     p1_err_r;
  logic [DATA_W-1:0]        bias_q_r;
  logic [ACC_W-1:0]         acc_r;

  logic [ACC_W-1:0]         bias_ext_s;
  logic [ACC_W-1:0]         p1_ext_s;
  logic [ACC_W-1:0]         acc_base_s;
  logic [ACC_W-1:0]         acc_next_s;

  // Beat acceptance, term counting and forced-termination decode.
  always_comb begin
    accept_s = in_valid && in_ready;
    first_s  = (state_r == IDLE);
    if (first_s) begin
      cnt_next_s = CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
    // A beat that reaches MAX_TERMS without in_last closes the vector with an error.
    force_s = (cnt_next_s == CNT_W'(MAX_TERMS)) && !in_last;
    last_s  = in_last || force_s;
    // The FSM is in ACCUM after this edge.
    if (first_s) begin
      stay_accum_s = accept_s && !last_s;
    end else begin
      stay_accum_s = !(accept_s && last_s);
    end
    prod_s = PROD_W'($signed(in_x)) * PROD_W'($signed(in_w));
  end

  // Vector framing FSM with term counter and registered busy/ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_W'(0);
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      busy     <= stay_accum_s || accept_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r <= cnt_next_s;
            if (!last_s) begin
              state_r <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept_s) begin
            cnt_r <= cnt_next_s;
            if (last_s) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_W'(0);
        end
      endcase
    end
  end

  // Stage 1: register the full-width product with its framing tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_r       <= PROD_W'(0);
      p1_valid_r <= 1'b0;
      p1_first_r <= 1'b0;
      p1_last_r  <= 1'b0;
      p1_err_r   <= 1'b0;
      bias_q_r   <= DATA_W'(0);
    end else begin
      p1_valid_r <= accept_s;
      if (accept_s) begin
        p1_r       <= prod_s;
        p1_first_r <= first_s;
        p1_last_r  <= last_s;
        p1_err_r   <= force_s;
        if (first_s) begin
          bias_q_r <= bias;
        end
      end
    end
  end

  // Stage 2 datapath: Q8.8 bias is shifted by 8 to line up with Q16.16 products.
  always_comb begin
    bias_ext_s = {{(ACC_W-DATA_W){bias_q_r[DATA_W-1]}}, bias_q_r} << 8;
    p1_ext_s   = {{(ACC_W-PROD_W){p1_r[PROD_W-1]}}, p1_r};
    if (p1_first_r) begin
      acc_base_s = bias_ext_s;
    end else begin
      acc_base_s = acc_r;
    end
    acc_next_s = acc_base_s + p1_ext_s;
  end

  // Stage 2: accumulate and publish the sum on the vector's last term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= ACC_W'(0);
      sum          <= ACC_W'(0);
      sum_valid    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      sum_valid    <= p1_valid_r && p1_last_r;
      overflow_err <= p1_valid_r && p1_last_r && p1_err_r;
      if (p1_valid_r) begin
        acc_r <= acc_next_s;
        if (p1_last_r) begin
          sum <= acc_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_perceptron_mac.sv
// -----------------------------------------------------------------------------
// tb_perceptron_mac
// Scoreboard bench for perceptron_mac (MAX_TERMS=4). A behavioural model pushes
// the expected sum, error flag and arrival edge for every vector as its beats
// are driven. A monitor pops and compares these on each sum_valid pulse.
// The observed sums are also checked against hand-derived constants at the end.
// -----------------------------------------------------------------------------
module tb_perceptron_mac;

  localparam int MAXT = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        in_last;
  logic [15:0] bias;
  logic        sum_valid;
  logic [47:0] sum;
  logic        overflow_err;
  logic        busy;

  perceptron_mac #(.DATA_W(16), .ACC_W(48), .MAX_TERMS(MAXT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_w         (in_w),
    .in_last      (in_last),
    .bias         (bias),
    .sum_valid    (sum_valid),
    .sum          (sum),
    .overflow_err (overflow_err),
    .busy         (busy)
  );

  typedef struct {
    logic [47:0] sum;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] obs_sum[$];
  logic        obs_err[$];
  exp_t        popped;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  logic signed [47:0] m_acc;
  int                 m_cnt;
  bit                 m_first;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one beat; the model predicts the result if this beat closes a vector.
  task automatic send(input logic [15:0] x, input logic [15:0] w,
                      input logic [15:0] b, input logic last);
    logic signed [47:0] prod;
    logic signed [47:0] bb;
    bit                 forced;
    exp_t               e;
    @(posedge clk);
    #1;
    check_eq("in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    bias     = b;
    in_last  = last;
    prod = $signed(x) * $signed(w);
    if (m_first) begin
      bb    = $signed(b);
      m_acc = bb * 48'sd256;
      m_cnt = 1;
    end else begin
      m_cnt++;
    end
    m_acc  = m_acc + prod;
    forced = (m_cnt == MAXT) && !last;
    if (last || forced) begin
      e.sum     = m_acc;
      e.err     = forced;
      e.edge_no = edge_cnt + 2;
      sb.push_back(e);
      m_first = 1'b1;
    end else begin
      m_first = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sum_valid) begin
        obs_sum.push_back(sum);
        obs_err.push_back(overflow_err);
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", 1, 0);
        end else begin
          popped = sb.pop_front();
          check_eq("sum", sum, popped.sum);
          check_eq("overflow_err", overflow_err, popped.err);
          check_eq("latency_edge", edge_cnt, popped.edge_no);
        end
      end else if (overflow_err) begin
        check_eq("err_without_valid", 1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [47:0] lit_sum[8];
  logic        lit_err[8];

  initial begin
    lit_sum = '{48'h0000_0000_C000, 48'hFFFF_FFFE_C000, 48'h0001_007F_FF00,
                48'h0000_0004_0000, 48'h0000_0003_0000, 48'h0000_0003_0000,
                48'h0000_0001_0000, 48'h0000_0006_1000};
    lit_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    m_first  = 1'b1;
    m_acc    = 48'sd0;
    m_cnt    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_x     = 16'h0000;
    in_w     = 16'h0000;
    in_last  = 1'b0;
    bias     = 16'h0000;

    #12;
    check_eq("rst_sum", sum, 0);
    check_eq("rst_sum_valid", sum_valid, 0);
    check_eq("rst_overflow", overflow_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1-term vector: 1.0 * 0.5 + 0.25
    send(16'h0100, 16'h0080, 16'h0040, 1'b1);
    idle(4);
    check_eq("busy_idle", busy, 0);

    // Signed 3-term vector, bias 0
    send(16'hFF00, 16'h0200, 16'h0000, 1'b0);
    send(16'h0100, 16'h0100, 16'h7777, 1'b0);
    check_eq("busy_mid", busy, 1);
    send(16'h0080, 16'hFF80, 16'h1234, 1'b1);
    idle(4);

    // Extremes: four (-128 * -128) terms with max positive bias
    send(16'h8000, 16'h8000, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h8000, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h8000, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    idle(4);

    // Forced termination at MAX_TERMS, then a 3-beat vector
    for (int i = 0; i < 6; i++) send(16'h0100, 16'h0100, 16'h0000, 1'b0);
    send(16'h0100, 16'h0100, 16'h0000, 1'b1);
    idle(4);

    // Back-to-back 2-term vectors
    send(16'h0100, 16'h0100, 16'h0100, 1'b0);
    send(16'h0100, 16'h0100, 16'h0000, 1'b1);
    send(16'h0100, 16'h0100, 16'hFF00, 1'b0);
    send(16'h0100, 16'h0100, 16'h0000, 1'b1);
    idle(4);
    check_eq("sb_drained", sb.size(), 0);

    // Asynchronous reset mid-vector
    send(16'h0100, 16'h0100, 16'h0100, 1'b0);
    send(16'h0100, 16'h0100, 16'h0100, 1'b0);
    @(posedge clk);
    #3;
    check_eq("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_sum", sum, 0);
    check_eq("abort_sum_valid", sum_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_first  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'h0200, 16'h0300, 16'h0010, 1'b1);
    idle(5);

    check_eq("sb_empty", sb.size(), 0);
    check_eq("pulse_count", obs_sum.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_sum.size()) begin
        check_eq($sformatf("lit_sum%0d", i), obs_sum[i], lit_sum[i]);
        check_eq($sformatf("lit_err%0d", i), obs_err[i], lit_err[i]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perceptron_mac.md
Name: perceptron_mac

Overview:
Streaming multiply-accumulate stage that forms one perceptron's weighted sum plus bias, sitting directly upstream of the activation stage.
- Input: one (input, weight) pair per beat over a valid/ready stream, with the vector's end marked by in_last.
- Output: a 48-bit signed Q.16 sum, registered with a one-cycle valid pulse. It drives the activation stage's x input, where 1.0 = 1<<16.

Parameters:
DATA_W, 16, width of in_x, in_w and bias; Q8.8 signed.
ACC_W, 48, accumulator and sum width; Q(ACC_W-16).16 signed.
MAX_TERMS, 256, maximum beats per vector before forced termination.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_x  in  DATA_W  signed input activation, Q8.8
in_w  in  DATA_W  signed weight, Q8.8
in_last  in  1  final beat of vector
bias  in  DATA_W  signed bias, Q8.8; sampled on a vector's first accepted beat
sum_valid  out  1  one-cycle pulse: sum updated
sum  out  ACC_W  signed weighted sum, Q.16; holds until next update
overflow_err  out  1  one-cycle pulse, coincident with sum_valid, when a vector was force-terminated
busy  out  1  high while a vector is partially accepted or in the pipeline

Behaviour:
- Reset (async, rst_n=0): sum=0, sum_valid=0, overflow_err=0, busy=0, in_ready=0. Pipeline valids, term counter and accumulator are cleared; FSM goes to IDLE. Any in-flight vector is discarded and no sum_valid is produced for it.
- in_ready is registered: 0 in reset, 1 from the first clk edge after rst_n deasserts. It stays 1 afterwards; the block never back-pressures.
- FSM states:
  - IDLE: the next accepted beat is the first of a vector. An accepted beat with in_last=0 goes to ACCUM; one with in_last=1 stays in IDLE (single-term vector).
  - ACCUM: an accepted beat with in_last=1, or the beat reaching MAX_TERMS, returns to IDLE. Otherwise stay.
- Term counter: set to 1 on a first beat and incremented per accepted beat in ACCUM. When an accepted beat makes the count equal MAX_TERMS with in_last=0, that beat is treated as last and its err flag is set. The following beat starts a new vector.
- Stage 1 (edge accepting the beat):
  - p1 <= in_x*in_w, full 2*DATA_W signed product, Q16.16.
  - The tags p1_valid, p1_first, p1_last and p1_err are registered with p1.
  - On a first beat, bias_q <= bias.
- Stage 2 (next edge, if p1_valid):
  - acc_next = (p1_first ? sext(bias_q)<<8 : acc) + sext(p1), computed at ACC_W and wrapping two's complement. No overflow is possible when MAX_TERMS ≤ 65536.
  - acc <= acc_next.
  - If p1_last: sum <= acc_next, sum_valid <= 1, overflow_err <= p1_err. Otherwise both pulses are 0.
- Latency: the last beat accepted at edge E0 gives sum and sum_valid updated at E0+1 cycle, so they are visible 2 edges after in_valid was sampled.
- Back-to-back: a new vector's first beat may be accepted on the cycle right after the previous last beat. p1_first reloads the bias, with no bubble. Full throughput is one beat per clock.
- in_valid=0 cycles mid-vector are allowed; the accumulator holds.
- busy = (state==ACCUM) || p1_valid.
- bias changes between first beat and last beat have no effect.

Test Plan:
- Reset then a 1-term vector: in_x=0x0100 (1.0), in_w=0x0080 (0.5), bias=0x0040 (0.25), in_last=1 → sum=48'h00_0000_C000 with sum_valid one cycle, 2 edges after acceptance; overflow_err=0.
- Signed 3-term vector with bias=0: (0xFF00,0x0200), (0x0100,0x0100), (0x0080,0xFF80) → products -0x20000, +0x10000, -0x4000 → sum=48'hFFFF_FFFE_C000 (-1.25).
- Extremes: 4 beats of (0x8000,0x8000), bias=0x7FFF → sum=0x1_0000_0000+0x7F_FF00=48'h0001_007F_FF00; no wrap.
- MAX_TERMS=4, six beats of (0x0100,0x0100) with no in_last, bias=0 → pulse at beat 4 with sum=0x40000 and overflow_err=1. Beats 5-6 followed by an in_last beat (a 3-beat vector) → sum=0x30000, overflow_err=0.
- Two back-to-back 2-term vectors, bias 0x0100 then 0xFF00, all pairs (0x0100,0x0100) → sum_valid pulses two cycles apart with 0x30000 then 0x10000; in_ready stays 1.
- Assert rst_n=0 asynchronously mid-vector (between clock edges) → sum, sum_valid and busy are 0 immediately. A fresh 1-term vector after release gives the correct sum with no residue; no pulse is seen for the aborted vector.
